// File: rtl/mult_share_arbiter_if.sv
// Signal bundle between requesters, mult_share_arbiter and the shared multiplier.
// The slave modport is the arbiter's view; master is the view of the surrounding environment.
interface mult_share_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [2*DATA_WIDTH-1:0]       rsp_data;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         mult_a;
  logic [DATA_WIDTH-1:0]         mult_b;
  logic                          mult_start;
  logic                          mult_done;
  logic [2*DATA_WIDTH-1:0]       mult_c;
  logic                          busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_done, mult_c,
    output req_ready, rsp_valid, rsp_data, rsp_err, mult_a, mult_b, mult_start, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_done, mult_c,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mult_a, mult_b, mult_start, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external variable-latency multiplier between NUM_REQ requesters,
// with a watchdog that turns a missing completion into an error response.
module mult_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 2*DATA_WIDTH+8
) (
  input logic                 clk,
  input logic                 rst,
  mult_share_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        grant_q;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic [WD_W-1:0]         wd;
  logic [DATA_WIDTH-1:0]   mult_a_q;
  logic [DATA_WIDTH-1:0]   mult_b_q;
  logic                    mult_start_q;
  logic                    busy_q;
  logic                    rsp_err_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [NUM_REQ-1:0]      req_ready_c;
  logic [2*DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0]   req_a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   req_b_arr [NUM_REQ];

  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) sum -= NUM_REQ;
    return IDX_W'(sum);
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_a_arr[k] = bus.req_a[k*DATA_WIDTH +: DATA_WIDTH];
    assign req_b_arr[k] = bus.req_b[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward so the requester closest to the pointer is the last (winning) assignment.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (bus.req_valid[rot_idx(ptr, i)]) begin
        grant_found = 1'b1;
        grant_idx   = rot_idx(ptr, i);
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (!rst && state == IDLE && grant_found) req_ready_c[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_q      <= '0;
      wd           <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      mult_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            grant_q      <= grant_idx;
            ptr          <= rot_idx(grant_idx, 1);
            mult_a_q     <= req_a_arr[grant_idx];
            mult_b_q     <= req_b_arr[grant_idx];
            mult_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        // mult_done may still be high from the previous job, so it is not looked at here.
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + WD_W'(1);
          if (bus.mult_done) begin
            rsp_data_q  <= bus.mult_c;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state       <= RESP;
          end else if (wd == WD_W'(TIMEOUT-1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.mult_start = mult_start_q;
  assign bus.busy       = busy_q;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one iterative two-speed radix-4 Booth multiplier (DATA_WIDTH operands, 2*DATA_WIDTH product, variable latency) between NUM_REQ requesters.
- Arbitrates round-robin, drives the multiplier's single-cycle start pulse and operands, and captures the product on completion.
- Returns the product to the granting requester through a valid/ready response channel.
- Sits between client pipelines and the multiplier instance; the multiplier itself is external.

Parameters:
- DATA_WIDTH, 32, operand width; even, >= 4.
- NUM_REQ, 4, number of requesters; >= 2.
- TIMEOUT, 2*DATA_WIDTH+8, watchdog limit in cycles from start pulse to multiplier completion.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; asserted only in the IDLE grant cycle.
- req_a  in  NUM_REQ*DATA_WIDTH  multiplicands, requester k at [k*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  multipliers, same packing.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response ready.
- rsp_data  out  2*DATA_WIDTH  product shared by all requesters; qualify with rsp_valid.
- rsp_err  out  1  response produced by watchdog expiry; rsp_data is 0 when set.
- mult_a  out  DATA_WIDTH  multiplier multiplicand.
- mult_b  out  DATA_WIDTH  multiplier multiplier.
- mult_start  out  1  single-cycle start pulse to the multiplier.
- mult_done  in  1  multiplier completion level.
- mult_c  in  2*DATA_WIDTH  multiplier product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer = 0.
  - Watchdog counter = 0.
  - Operand, product, grant and error registers = 0.
- Reset mid-operation: the transaction is abandoned with no response. The multiplier is not reset by this block. A stale mult_done is ignored until the next start.
- State IDLE:
  - Grant goes to the first requester with req_valid set, searching from pointer upward with wrap.
  - Same cycle: req_ready[g]=1 (combinational); req_a/req_b[g] are latched into mult_a/mult_b; grant index is stored.
  - Pointer becomes (g+1) mod NUM_REQ.
  - Next state is ISSUE. No req_valid means stay in IDLE.
- State ISSUE:
  - mult_start=1 for exactly this one cycle; mult_a/mult_b stay stable from ISSUE until leaving WAIT.
  - mult_done is ignored here, because the multiplier holds done from its previous job until it sees start.
  - Watchdog is cleared. Next state is WAIT.
- State WAIT:
  - Watchdog increments each cycle.
  - The first cycle with mult_done=1 captures mult_c and sets rsp_err=0; next state is RESP.
  - If the watchdog reaches TIMEOUT with no done: rsp_data=0, rsp_err=1, next state is RESP.
  - If done and timeout occur in the same cycle, done wins.
- State RESP:
  - rsp_valid[grant]=1; rsp_data and rsp_err are held stable.
  - Waits on rsp_ready[grant]; other requesters' rsp_ready bits are ignored.
  - On handshake, next state is IDLE. A new grant is possible the following cycle, not the same cycle.
- Throughput:
  - One transaction in flight; never more than one rsp_valid bit set.
  - Minimum request-to-response = 3 cycles plus multiplier latency.
- Product format and fairness:
  - Products are passed through unchanged: signed two's-complement, 2*DATA_WIDTH bits. No saturation or truncation.
  - A continuously requesting requester waits at most NUM_REQ-1 transactions.
  - A req_valid dropped before grant is permitted; the requester is skipped.

Test Plan:
1. Single request, DATA_WIDTH=32: requester 2 sends a=7, b=-3 -> one mult_start pulse; rsp_valid=4'b0100, rsp_data=64'hFFFF_FFFF_FFFF_FFEB, rsp_err=0.
2. All four requesters held valid, pointer=0 -> grants in order 0,1,2,3,0. Each response goes to the matching one-hot bit with the correct product (a=k+1, b=10 gives 10,20,30,40).
3. Back-pressure: rsp_ready held low 20 cycles in RESP -> rsp_valid and rsp_data stable, no new req_ready, no mult_start. Releasing rsp_ready returns to IDLE in 1 cycle.
4. Stale done: mult_done left high from the previous job during ISSUE -> not captured; the product from the new job is returned.
5. Watchdog: mult_done tied low -> rsp_valid exactly TIMEOUT+2 cycles after grant, rsp_err=1, rsp_data=0; the next transaction then completes normally.
6. Reset asserted mid-WAIT -> outputs 0 asynchronously and no response issued. After release, pointer=0 and requester 0 wins over 3.
